led_blinker_multi: RTL and testbench
====================================

Name: led_blinker_multi

Overview:
Multi-channel LED pattern generator and the successor of the single-LED fixed-period blinker.
- One shared millisecond prescaler drives N_CH independent channels.
- Each channel has a runtime-programmable mode, asymmetric on/off times and a finite-burst option.
- Sits between the board's control logic (switches or a register interface) and the LED pins.

Parameters:
CLK_FREQ_HZ, 100_000_000, input clock frequency.
TICK_HZ, 1000, time-base rate; DIV = CLK_FREQ_HZ/TICK_HZ, must be >= 2 (elaboration assertion).
N_CH, 4, number of LED channels, 1..16.
TW, 16, width of on/off time fields, in ticks.
BW, 8, width of burst-count field.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sync  in  1  1-cycle pulse: restart prescaler and phase of all channels
cfg_we  in  1  config write strobe, one channel per cycle
cfg_ch  in  $clog2(N_CH) (min 1)  target channel
cfg_mode  in  2  mode_e: OFF=0, ON=1, BLINK=2, BURST=3
cfg_on  in  TW  on-time in ticks
cfg_off  in  TW  off-time in ticks
cfg_burst  in  BW  number of on/off cycles for BURST mode
tick  out  1  1-cycle pulse at TICK_HZ
led  out  N_CH  LED drive, registered
busy  out  N_CH  channel is in an active BURST
done  out  N_CH  1-cycle pulse when a BURST completes

Behaviour:
- Reset (sync, active-high, all registered state):
  - Prescaler = 0.
  - Every channel: mode OFF, on/off/burst registers 0, phase IDLE.
  - led, busy, done and tick all 0.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - tick = 1 in the cycle the count equals DIV-1.
  - sync forces the count to 0 on the next edge; the first tick after sync arrives exactly DIV cycles later.
- Config write (cfg_we = 1):
  - Latches mode/on/off/burst into channel cfg_ch.
  - Restarts that channel on the next edge.
  - Other channels are unaffected.
  - cfg_ch >= N_CH is ignored.
- Channel FSM, phases IDLE, ON, OFF. Effective times: T_on = max(cfg_on, 1), T_off = max(cfg_off, 1).
  - OFF mode: phase IDLE, led 0.
  - ON mode: phase IDLE, led 1.
  - BLINK mode: restart enters ON with the tick counter at 0. In ON, led = 1. After T_on ticks the channel goes to OFF with the counter at 0 and led = 0. After T_off ticks it returns to ON. Repeats forever.
  - BURST mode: same as BLINK, plus a remaining-cycle counter loaded with cfg_burst at restart.
    - Each OFF→ON boundary decrements the counter.
    - When an OFF phase ends with remaining = 1, go to IDLE, led = 0, busy falls and done pulses for one cycle, all on the same edge.
    - busy = 1 from the restart edge until that edge.
    - cfg_burst = 0: on the restart edge go straight to IDLE; busy stays 0, done pulses once.
- Latency:
  - led reflects a new config one cycle after cfg_we: ON/BLINK/BURST (burst > 0) give led = 1; OFF gives led = 0.
  - The first phase is not aligned to the prescaler: it lasts between T-1 and T ticks (sub-tick jitter is allowed). All later phases are exactly T ticks. After sync, phases are exact from the start.
- sync: every channel in BLINK or BURST restarts its current cycle in ON (counter 0). The remaining burst count is not reloaded.
- Simultaneous events:
  - cfg_we and a tick in the same cycle for the same channel: the write wins and that tick is not counted.
  - cfg_we and sync in the same cycle: both apply; the written channel restarts with the aligned prescaler.
- Tick counters are TW bits wide and saturate-compare against T; no wrap occurs because T <= 2^TW - 1.
- Reset asserted mid-burst: immediate return to reset state; no done pulse is generated.

Decomposition:
- Package led_pkg:
  - mode_e (2-bit enum) and phase_e (IDLE/ON/OFF).
  - A function computing DIV from CLK_FREQ_HZ/TICK_HZ.
  - Constant MODE_W = 2.
- Sub-module led_channel (one FSM, its config registers and counters), instantiated N_CH times in a generate loop.
- Prescaler and write decode stay in the top.

Test Plan:
Common setup for all scenarios: CLK_FREQ_HZ = 1000, TICK_HZ = 100, so DIV = 10.
1. Reset, then idle 50 cycles -> led = 0, busy = 0, done = 0; tick pulses every 10 cycles starting at cycle 10 after reset release.
2. sync, then in the same cycle cfg_we with ch 0, BLINK, on = 3, off = 2 -> led[0] = 1 for exactly 30 cycles, then 0 for 20, period 50, checked over 5 periods; led[1..3] stay 0.
3. sync plus ch 1 BURST, on = 1, off = 1, burst = 3 -> three 10-cycle highs; busy[1] = 1 for 60 cycles; done[1] pulses once on the edge where busy falls; then led[1] = 0 permanently.
4. ch 2 BURST with burst = 0 -> done[2] pulses on the cycle after the write, busy[2] never rises; ch 3 with on = 0, off = 0 in BLINK -> 10-cycle high/low (zero treated as 1).
5. Mid-blink rewrite of ch 0 to ON, issued in the same cycle as a tick -> led[0] = 1 on the next cycle and stays 1; apply sync during a ch 0 OFF phase in BLINK -> led[0] = 1 on the next cycle, phase re-aligned.
6. Assert reset during a ch 1 burst with 2 cycles remaining -> all outputs 0 on the next edge, no done pulse; cfg_ch = N_CH write -> no channel changes.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
package led_pkg;

  localparam int MODE_W = 2;

  // Channel operating mode as written through the config port.
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  // Per-channel pattern phase; IDLE covers steady OFF/ON and finished bursts.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_ON   = 2'd1,
    PH_OFF  = 2'd2
  } phase_e;

  // Prescaler divide ratio from the clock and time-base rates.
  function automatic int calc_div(input int clk_freq_hz, input int tick_hz);
    return clk_freq_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_blinker_multi_channel.sv
// One LED channel: config registers, phase FSM, tick counter and burst counter.
// All registered state lives in st_q so checkers can bind to a single struct.
module led_channel
  import led_pkg::*;
#(
  parameter int TW = 16,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          sync,
  input  logic          wr,
  input  mode_e         cfg_mode,
  input  logic [TW-1:0] cfg_on,
  input  logic [TW-1:0] cfg_off,
  input  logic [BW-1:0] cfg_burst,
  output logic          led,
  output logic          busy,
  output logic          done
);

  typedef struct packed {
    mode_e         mode;
    logic [TW-1:0] on_t;
    logic [TW-1:0] off_t;
    logic [BW-1:0] burst;
    logic [TW-1:0] cnt;
    logic [BW-1:0] rem;
    phase_e        phase;
    logic          led;
    logic          busy;
    logic          done;
  } ch_state_t;

  ch_state_t     st_q;
  ch_state_t     st_d;
  logic [TW-1:0] t_on_last;
  logic [TW-1:0] t_off_last;

  // Last tick index of each phase; a zero time field behaves as one tick.
  always_comb begin
    t_on_last  = (st_q.on_t  == '0) ? '0 : st_q.on_t  - TW'(1);
    t_off_last = (st_q.off_t == '0) ? '0 : st_q.off_t - TW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) st_q <= '0;
    else       st_q <= st_d;
  end

  // Next state: a write beats sync, sync beats a tick.
  always_comb begin
    st_d      = st_q;
    st_d.done = 1'b0;
    if (wr) begin
      st_d.mode  = cfg_mode;
      st_d.on_t  = cfg_on;
      st_d.off_t = cfg_off;
      st_d.burst = cfg_burst;
      st_d.rem   = cfg_burst;
      st_d.cnt   = '0;
      st_d.phase = PH_IDLE;
      st_d.led   = 1'b0;
      st_d.busy  = 1'b0;
      case (cfg_mode)
        MODE_ON:    st_d.led = 1'b1;
        MODE_BLINK: begin
          st_d.phase = PH_ON;
          st_d.led   = 1'b1;
        end
        MODE_BURST: begin
          if (cfg_burst == '0) begin
            st_d.done = 1'b1;
          end else begin
            st_d.phase = PH_ON;
            st_d.led   = 1'b1;
            st_d.busy  = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (sync) begin
      if (st_q.phase != PH_IDLE) begin
        st_d.phase = PH_ON;
        st_d.cnt   = '0;
        st_d.led   = 1'b1;
      end
    end else if (tick) begin
      case (st_q.phase)
        PH_ON: begin
          if (st_q.cnt >= t_on_last) begin
            st_d.phase = PH_OFF;
            st_d.cnt   = '0;
            st_d.led   = 1'b0;
          end else begin
            st_d.cnt = st_q.cnt + TW'(1);
          end
        end
        PH_OFF: begin
          if (st_q.cnt >= t_off_last) begin
            st_d.cnt = '0;
            if (st_q.mode == MODE_BURST && st_q.rem <= BW'(1)) begin
              st_d.phase = PH_IDLE;
              st_d.busy  = 1'b0;
              st_d.done  = 1'b1;
            end else begin
              if (st_q.mode == MODE_BURST) st_d.rem = st_q.rem - BW'(1);
              st_d.phase = PH_ON;
              st_d.led   = 1'b1;
            end
          end else begin
            st_d.cnt = st_q.cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign led  = st_q.led;
  assign busy = st_q.busy;
  assign done = st_q.done;

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED pattern generator: shared prescaler, write decode and
// N_CH independent led_channel instances.
// Config port: cfg_we is a single-cycle strobe with no ready; every strobe
// addressing an existing channel is accepted on that edge.
module led_blinker_multi
  import led_pkg::*;
#(
  parameter int  CLK_FREQ_HZ = 100_000_000,
  parameter int  TICK_HZ     = 1000,
  parameter int  N_CH        = 4,
  parameter int  TW          = 16,
  parameter int  BW          = 8,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [TW-1:0]     cfg_on,
  input  logic [TW-1:0]     cfg_off,
  input  logic [BW-1:0]     cfg_burst,
  output logic              tick,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   done
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("led_blinker_multi: CLK_FREQ_HZ/TICK_HZ must be at least 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_nch_check
    $error("led_blinker_multi: N_CH must be in 1..16");
  end

  logic [PW-1:0] pre_q;

  // Millisecond prescaler; sync realigns it so the next tick is DIV cycles out.
  always_ff @(posedge clk) begin
    if (reset)                        pre_q <= '0;
    else if (sync)                    pre_q <= '0;
    else if (pre_q == PW'(DIV - 1))   pre_q <= '0;
    else                              pre_q <= pre_q + PW'(1);
  end

  assign tick = (pre_q == PW'(DIV - 1));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr;
    // Write decode: out-of-range channel numbers match no instance.
    assign wr = cfg_we && (cfg_ch == CH_W'(i));

    led_channel #(
      .TW (TW),
      .BW (BW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .sync      (sync),
      .wr        (wr),
      .cfg_mode  (mode_e'(cfg_mode)),
      .cfg_on    (cfg_on),
      .cfg_off   (cfg_off),
      .cfg_burst (cfg_burst),
      .led       (led[i]),
      .busy      (busy[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Bench for led_blinker_multi with DIV = 10 and five channels (three-bit
// channel field so out-of-range numbers can be written).
module tb_led_blinker_multi;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int TICK_HZ     = 100;
  localparam int DIV         = 10;
  localparam int N_CH        = 5;
  localparam int TW          = 16;
  localparam int BW          = 8;
  localparam int CH_W        = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            sync;
  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [1:0]      cfg_mode;
  logic [TW-1:0]   cfg_on;
  logic [TW-1:0]   cfg_off;
  logic [BW-1:0]   cfg_burst;
  logic            tick;
  logic [N_CH-1:0] led;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  led_blinker_multi #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TICK_HZ     (TICK_HZ),
    .N_CH        (N_CH),
    .TW          (TW),
    .BW          (BW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_on    (cfg_on),
    .cfg_off   (cfg_off),
    .cfg_burst (cfg_burst),
    .tick      (tick),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  // Reference model: each pattern is described by the number of ticks seen
  // since its last restart (m_k) plus whole cycles finished before the last
  // sync (m_base); outputs follow from modular arithmetic on those numbers.
  int m_cnt;
  int m_mode  [N_CH];
  int m_on    [N_CH];
  int m_off   [N_CH];
  int m_burst [N_CH];
  int m_k     [N_CH];
  int m_base  [N_CH];
  bit m_done  [N_CH];

  function automatic int eff(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  function automatic int period(input int c);
    return eff(m_on[c]) + eff(m_off[c]);
  endfunction

  function automatic bit finished(input int c);
    return (m_mode[c] == 3) && ((m_base[c] + m_k[c] / period(c)) >= m_burst[c]);
  endfunction

  function automatic bit exp_led(input int c);
    case (m_mode[c])
      1:       return 1'b1;
      2:       return (m_k[c] % period(c)) < eff(m_on[c]);
      3:       return !finished(c) && ((m_k[c] % period(c)) < eff(m_on[c]));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [N_CH-1:0] exp_led_vec();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = exp_led(c);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_busy_vec();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = (m_mode[c] == 3) && !finished(c);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] exp_done_vec();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = m_done[c];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_mode[c] = 0; m_on[c] = 0; m_off[c] = 0; m_burst[c] = 0;
      m_k[c] = 0; m_base[c] = 0; m_done[c] = 1'b0;
    end
  endtask

  // One clock: advance the model with the inputs of this cycle, then compare.
  task automatic step();
    bit t;
    bit fp;
    t = (m_cnt == DIV - 1);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_cnt = sync ? 0 : (t ? 0 : m_cnt + 1);
      for (int c = 0; c < N_CH; c++) begin
        fp        = finished(c);
        m_done[c] = 1'b0;
        if (cfg_we && int'(cfg_ch) == c) begin
          m_mode[c]  = int'(cfg_mode);
          m_on[c]    = int'(cfg_on);
          m_off[c]   = int'(cfg_off);
          m_burst[c] = int'(cfg_burst);
          m_k[c]     = 0;
          m_base[c]  = 0;
          m_done[c]  = (m_mode[c] == 3) && (m_burst[c] == 0);
        end else if (sync) begin
          if (m_mode[c] == 2 || (m_mode[c] == 3 && !fp)) begin
            m_base[c] = m_base[c] + m_k[c] / period(c);
            m_k[c]    = 0;
          end
        end else if (t) begin
          if (m_mode[c] == 2 || (m_mode[c] == 3 && !fp)) m_k[c]++;
          m_done[c] = (m_mode[c] == 3) && !fp && finished(c);
        end
      end
    end
    #1;
    check("tick", 32'(tick), 32'(m_cnt == DIV - 1));
    check("led",  32'(led),  32'(exp_led_vec()));
    check("busy", 32'(busy), 32'(exp_busy_vec()));
    check("done", 32'(done), 32'(exp_done_vec()));
  endtask

  task automatic idle_inputs();
    sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_on = '0; cfg_off = '0; cfg_burst = '0;
  endtask

  task automatic set_write(input int ch, input int mode, input int on_t,
                           input int off_t, input int burst);
    cfg_we    = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_mode  = 2'(mode);
    cfg_on    = TW'(on_t);
    cfg_off   = TW'(off_t);
    cfg_burst = BW'(burst);
  endtask

  // Directed scenarios followed by a randomized soak.
  initial begin
    int  cnt_a;
    int  cnt_b;
    int  cnt_c;
    bit  found;

    idle_inputs();
    model_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Idle after reset: everything dark, ticks every DIV cycles.
    cnt_a = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tick) cnt_a++;
    end
    check("idle_tick_count", 32'(cnt_a), 32'd5);

    // Aligned BLINK 3/2 on ch0: 30 high, 20 low, five periods.
    sync = 1'b1; set_write(0, 2, 3, 2, 0);
    cnt_a = 0;
    for (int i = 0; i < 250; i++) begin
      step();
      idle_inputs();
      if (led[0]) cnt_a++;
    end
    check("blink_high_cycles", 32'(cnt_a), 32'd150);

    // Aligned BURST 1/1 x3 on ch1.
    sync = 1'b1; set_write(1, 3, 1, 1, 3);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      idle_inputs();
      if (busy[1]) cnt_a++;
      if (done[1]) cnt_b++;
      if (led[1])  cnt_c++;
    end
    check("burst_busy_cycles", 32'(cnt_a), 32'd60);
    check("burst_done_pulses", 32'(cnt_b), 32'd1);
    check("burst_led_cycles",  32'(cnt_c), 32'd30);

    // Zero-length burst on ch2, then zero times in BLINK on ch3.
    set_write(2, 3, 2, 2, 0);
    step();
    idle_inputs();
    check("burst0_done", 32'(done[2]), 32'd1);
    repeat (20) step();
    sync = 1'b1; set_write(3, 2, 0, 0, 0);
    cnt_a = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      idle_inputs();
      if (led[3]) cnt_a++;
    end
    check("blink_zero_high", 32'(cnt_a), 32'd20);

    // Rewrite ch0 to ON in a tick cycle.
    found = 1'b0;
    for (int i = 0; i < 2 * DIV && !found; i++) begin
      if (m_cnt == DIV - 1) found = 1'b1;
      else step();
    end
    check("wait_tick", 32'(found), 32'd1);
    set_write(0, 1, 3, 2, 0);
    step();
    idle_inputs();
    check("rewrite_on_led", 32'(led[0]), 32'd1);
    repeat (30) step();

    // sync during an OFF phase of ch0 in BLINK.
    set_write(0, 2, 2, 3, 0);
    step();
    idle_inputs();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (!exp_led(0)) found = 1'b1;
      else step();
    end
    check("wait_off_phase", 32'(found), 32'd1);
    sync = 1'b1;
    step();
    idle_inputs();
    check("sync_led_on", 32'(led[0]), 32'd1);
    repeat (60) step();

    // Reset in the middle of a burst.
    set_write(1, 3, 1, 1, 3);
    step();
    idle_inputs();
    repeat (25) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_led",  32'(led),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (30) step();

    // Out-of-range channel numbers change nothing.
    set_write(4, 2, 1, 2, 0);
    step();
    for (int ch = N_CH; ch < 8; ch++) begin
      set_write(ch, 1, 5, 5, 5);
      step();
    end
    idle_inputs();
    repeat (20) step();

    // Randomized soak.
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      reset = ($urandom_range(0, 499) == 0);
      sync  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin
        set_write($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 4));
      end
      step();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
